// File: rtl/apu_pkg.sv
// apu_pkg: shared state type and default constants for the APU DMA arbiter
package apu_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, OAM_GET, OAM_PUT, DMC_GET} arb_state_e;
  localparam int OAM_LEN_DEFAULT = 256;
  localparam logic [15:0] OAM_DEST_DEFAULT = 16'h2004;
endpackage

// File: rtl/apu_dma_parity.sv
// apu_dma_parity: get/put cycle parity tracker and "next cycle is get" helper
module apu_dma_parity (
  input  logic clk,
  input  logic rst_n,
  output logic next_get
);
  logic put_phase;
  // put_phase alternates every CPU cycle: 0 = get, 1 = put
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) put_phase <= 1'b0;
    else put_phase <= ~put_phase;
  assign next_get = put_phase;
endmodule

// File: rtl/apu_dma_arbiter.sv
// apu_dma_arbiter: shares the CPU bus between core, OAM DMA and DMC DMA (optional APU_DMA_DUMMY_READ_EN)
module apu_dma_arbiter
  import apu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int OAM_LEN = OAM_LEN_DEFAULT,
  parameter logic [ADDR_W-1:0] OAM_DEST = ADDR_W'(OAM_DEST_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [7:0]        cpu_data_i,
  input  logic              cpu_rw_i,
  input  logic [7:0]        bus_data_i,
  input  logic              oam_req,
  input  logic [7:0]        oam_page,
  input  logic              dmc_req,
  input  logic [ADDR_W-1:0] dmc_addr,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        data_o,
  output logic              rw_o,
  output logic              cpu_halt,
  output logic [7:0]        dmc_data,
  output logic              dmc_valid,
  output logic              oam_busy
);
  arb_state_e state, align_next;
  logic next_get, dmc_pend;
  logic [7:0] page, idx, oam_byte;
  logic [ADDR_W-1:0] dummy_addr;

  apu_dma_parity u_parity (.clk(clk), .rst_n(rst_n), .next_get(next_get));

`ifdef APU_DMA_DUMMY_READ_EN
  assign dummy_addr = cpu_addr_i;
`else
  assign dummy_addr = '0;
`endif

  // the strobe cycle masks the still-high request so one fetch is not taken twice
  assign dmc_pend = dmc_req & ~dmc_valid;
  assign align_next = dmc_pend ? (next_get ? DMC_GET : ALIGN)
                    : oam_busy ? (next_get ? OAM_GET : ALIGN) : IDLE;
  // the core stays held through the cycle the fetched DMC byte is delivered
  assign cpu_halt = (state != IDLE) || dmc_valid;

  // bus mux: core pass-through except while a DMA phase owns the bus
  always_comb begin
    addr_o = cpu_addr_i;
    data_o = cpu_data_i;
    rw_o = cpu_rw_i;
    case (state)
      HALT, ALIGN: begin addr_o = dummy_addr; rw_o = 1'b1; end
      OAM_GET: begin addr_o = dmc_pend ? dmc_addr : ADDR_W'({page, idx}); rw_o = 1'b1; end
      OAM_PUT: begin addr_o = OAM_DEST; data_o = oam_byte; rw_o = 1'b0; end
      DMC_GET: begin addr_o = dmc_addr; rw_o = 1'b1; end
      default: ;
    endcase
  end

  // arbitration FSM with OAM sequencing and DMC capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      oam_busy <= 1'b0;
      page <= '0;
      idx <= '0;
      oam_byte <= '0;
      dmc_data <= '0;
      dmc_valid <= 1'b0;
    end else begin
      dmc_valid <= 1'b0;
      if (oam_req && !oam_busy) begin
        oam_busy <= 1'b1;
        page <= oam_page;
        idx <= '0;
      end
      case (state)
        IDLE: if ((oam_busy || dmc_pend) && cpu_rw_i) state <= HALT;
        HALT, ALIGN: state <= align_next;
        OAM_GET:
          if (dmc_pend) begin
            dmc_data <= bus_data_i;
            dmc_valid <= 1'b1;
            state <= ALIGN;
          end else begin
            oam_byte <= bus_data_i;
            state <= OAM_PUT;
          end
        OAM_PUT: begin
          idx <= idx + 8'd1;
          if (idx == 8'(OAM_LEN - 1)) begin
            oam_busy <= 1'b0;
            state <= IDLE;
          end else state <= OAM_GET;
        end
        DMC_GET: begin
          dmc_data <= bus_data_i;
          dmc_valid <= 1'b1;
          state <= oam_busy ? ALIGN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/apu_dma_arbiter.md
Name: apu_dma_arbiter

Overview:
Shares the CPU bus between the 6502 core, OAM sprite DMA ($4014) and DMC sample fetch DMA. It halts the core and inserts alignment cycles on get/put parity. It then sequences the DMA get/put transfers and returns the bus to the core. It sits between the core and the external bus inside the APU/CPU top, and replaces the stand-alone OAM DMA path. One clk equals one CPU cycle.

Parameters:
OAM_LEN, 256, number of bytes per OAM transfer
OAM_DEST, 16'h2004, write address for OAM put cycles
ADDR_W, 16, bus address width

Ports:
clk  in  1  CPU-cycle clock
rst_n  in  1  asynchronous active-low reset
cpu_addr_i  in  16  core address
cpu_data_i  in  8  core write data
cpu_rw_i  in  1  core rw (1 = read)
bus_data_i  in  8  read data from bus
oam_req  in  1  one-cycle pulse: core wrote $4014
oam_page  in  8  page byte written to $4014
dmc_req  in  1  level: DMC sample buffer empty, fetch needed
dmc_addr  in  16  DMC fetch address
addr_o  out  16  bus address
data_o  out  8  bus write data
rw_o  out  1  bus rw
cpu_halt  out  1  deassert core READY
dmc_data  out  8  fetched DMC byte
dmc_valid  out  1  one-cycle strobe with dmc_data
oam_busy  out  1  OAM transfer in progress

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, put_phase=0, cpu_halt=0, oam_busy=0, dmc_valid=0, dmc_data=0.
  - Bus outputs pass the core through: addr_o=cpu_addr_i, data_o=cpu_data_i, rw_o=cpu_rw_i.
- put_phase toggles every clk; 0 = get cycle, 1 = put cycle.
- oam_req is latched into a pending flag. dmc_req is sampled as a level. A new oam_req while oam_busy is ignored.
- States: IDLE, HALT, ALIGN, OAM_GET, OAM_PUT, DMC_GET.
- IDLE:
  - Pass-through.
  - On a pending request with cpu_rw_i=1, go to HALT and assert cpu_halt combinationally from the registered state.
  - Halt only takes on core read cycles. While cpu_rw_i=0, stay in IDLE; the request remains pending.
- HALT:
  - One cycle.
  - If DMC is pending and put_phase=1 (next cycle is get), go to DMC_GET; otherwise go to ALIGN.
  - If only OAM is pending: go to OAM_GET if the next cycle is get, else ALIGN.
- ALIGN: one cycle; re-evaluates as HALT does. Total overhead is 1–2 cycles.
- DMC_GET:
  - addr_o=dmc_addr, rw_o=1.
  - dmc_data<=bus_data_i and dmc_valid=1 on the following cycle.
  - Then resume OAM if busy, else go to IDLE (cpu_halt drops the next cycle).
- OAM_GET:
  - addr_o={oam_page,idx[7:0]}, rw_o=1; latch the byte.
  - If DMC is pending here, DMC takes this get slot instead (priority DMC > OAM) and OAM_GET is retried on a later get after one ALIGN.
- OAM_PUT:
  - addr_o=OAM_DEST, rw_o=0, data_o=latched byte, idx++.
  - When idx wraps past OAM_LEN-1, go to IDLE and clear oam_busy.
- OAM timing: 513 cycles for an even-aligned start and 514 for odd, from the HALT cycle to the last put inclusive. Each DMC steal adds 2 cycles.
- The 8-bit idx wraps naturally at 256.
- Simultaneous oam_req and dmc_req: DMC is serviced first.
- rst_n asserted mid-transfer aborts immediately. No partial state survives reset; the pending flags are cleared.

Optional Feature:
APU_DMA_DUMMY_READ_EN:
- Defined: during HALT and ALIGN, drive addr_o=cpu_addr_i with rw_o=1. This reproduces the hardware double-read of $4016/$4017.
- Undefined: HALT and ALIGN drive addr_o=16'h0000 with rw_o=1 (harmless RAM read).

Decomposition:
- Package apu_pkg: arb_state_e enum, OAM_DEST_DEFAULT and OAM_LEN_DEFAULT constants.
- One natural sub-module, apu_dma_parity: put_phase toggle plus the "next cycle is get" helper. The remainder is a single FSM with datapath.

Test Plan:
- oam_req, oam_page=8'h02, even start, no DMC -> 256 writes to $2004 with data from $0200..$02FF in order; cpu_halt high exactly 513 cycles.
- Same request started on an odd cycle -> cpu_halt high 514 cycles; first read at $0200 lands on a get cycle.
- oam_req while cpu_rw_i=0 for 3 cycles -> HALT entered only on the first read cycle; no bus cycle is lost or duplicated.
- dmc_req with dmc_addr=16'hC000, IDLE -> one read at $C000; dmc_valid pulses with bus byte 8'hA5; cpu_halt lasts 3–4 cycles.
- dmc_req asserted at OAM byte 100 -> DMC read inserted on a get slot; OAM bytes stay contiguous; total halt = 513/514 + 2.
- rst_n low during OAM byte 50 -> outputs at reset values asynchronously; after release, core pass-through with no residual DMA.
